// File: rtl/bird_pkg.sv
// Shared constants and types for the bird game rendering blocks.
package bird_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_SKY  = 3'b011;
    localparam logic [2:0] COLOUR_BIRD = 3'b110;
    localparam logic [2:0] COLOUR_PIPE = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } render_state_e;

endpackage

// File: rtl/sprite_scanner.sv
// Row-major pixel scan counters for a W x H sprite; dx is the inner loop.
module sprite_scanner #(
    parameter int W = 4,
    parameter int H = 4,
    parameter int DX_W = (W > 1) ? $clog2(W) : 1,
    parameter int DY_W = (H > 1) ? $clog2(H) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            enable,
    output logic [DX_W-1:0] dx,
    output logic [DY_W-1:0] dy,
    output logic            last
);

    localparam logic [DX_W-1:0] DX_MAX = DX_W'(W - 1);
    localparam logic [DY_W-1:0] DY_MAX = DY_W'(H - 1);

    logic [DX_W-1:0] dx_q, dx_d;
    logic [DY_W-1:0] dy_q, dy_d;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (start) begin
            dx_d = '0;
            dy_d = '0;
        end else if (enable) begin
            if (dx_q == DX_MAX) begin
                dx_d = '0;
                // Both counters wrap to zero after the last pixel, ready for the next pass.
                dy_d = (dy_q == DY_MAX) ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx   = dx_q;
    assign dy   = dy_q;
    assign last = (dx_q == DX_MAX) && (dy_q == DY_MAX);

endmodule

// File: rtl/bird_renderer.sv
// Erases the bird sprite at its old row and redraws it at the new row, one pixel per cycle.
module bird_renderer
    import bird_pkg::*;
#(
    parameter int         BIRD_X      = 20,
    parameter int         BIRD_W      = 4,
    parameter int         BIRD_H      = 4,
    parameter logic [2:0] BIRD_COLOUR = COLOUR_BIRD,
    parameter logic [2:0] SKY_COLOUR  = COLOUR_SKY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [6:0] bird_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done
);

    localparam int         DX_W  = (BIRD_W > 1) ? $clog2(BIRD_W) : 1;
    localparam int         DY_W  = (BIRD_H > 1) ? $clog2(BIRD_H) : 1;
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - BIRD_H);

    if (BIRD_X + BIRD_W - 1 > SCREEN_W - 1) begin : g_bad_bird_x
        $error("bird_renderer: sprite extends past the right edge of the screen");
    end

    render_state_e state_q, state_d;
    logic [6:0]    old_y_q, old_y_d;
    logic [6:0]    new_y_q, new_y_d;
    logic          have_old_q, have_old_d;
    logic [6:0]    y_clamped;

    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;
    logic            scan_last;
    logic            scan_start;
    logic            scan_en;

    sprite_scanner #(
        .W    (BIRD_W),
        .H    (BIRD_H),
        .DX_W (DX_W),
        .DY_W (DY_W)
    ) u_scanner (
        .clk    (clk),
        .reset  (reset),
        .start  (scan_start),
        .enable (scan_en),
        .dx     (dx),
        .dy     (dy),
        .last   (scan_last)
    );

    // Keep the whole sprite on screen so vga_y never exceeds the last row.
    assign y_clamped = (bird_y > Y_MAX) ? Y_MAX : bird_y;

    always_comb begin
        state_d    = state_q;
        old_y_d    = old_y_q;
        new_y_d    = new_y_q;
        have_old_d = have_old_q;
        scan_start = 1'b0;
        scan_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                scan_start = 1'b1;
                if (frame_tick) begin
                    new_y_d = y_clamped;
                    if (!have_old_q) begin
                        state_d = DRAW;
                    end else if (y_clamped != old_y_q) begin
                        state_d = ERASE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ERASE: begin
                scan_en = 1'b1;
                if (scan_last) state_d = DRAW;
            end
            DRAW: begin
                scan_en = 1'b1;
                if (scan_last) state_d = DONE;
            end
            DONE: begin
                old_y_d    = new_y_q;
                have_old_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registered state and scan counters.
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (state_q == ERASE) begin
            vga_plot   = 1'b1;
            vga_x      = 8'(BIRD_X) + 8'(dx);
            vga_y      = old_y_q + 7'(dy);
            vga_colour = SKY_COLOUR;
        end else if (state_q == DRAW) begin
            vga_plot   = 1'b1;
            vga_x      = 8'(BIRD_X) + 8'(dx);
            vga_y      = new_y_q + 7'(dy);
            vga_colour = BIRD_COLOUR;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            old_y_q    <= '0;
            new_y_q    <= '0;
            have_old_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            old_y_q    <= old_y_d;
            new_y_q    <= new_y_d;
            have_old_q <= have_old_d;
        end
    end

endmodule

// File: doc/bird_renderer.md
# bird_renderer

Draws the bird sprite on the 160x120 VGA frame buffer, directly downstream of the bird control FSM. Once per frame tick it latches the bird's vertical position. It erases the sprite at the previous position with the sky colour, then draws it at the new position. Output is one pixel-plot request per cycle to the VGA adapter. The bird column is fixed, so only y moves.

## Interface
- `BIRD_X`, 20: fixed left column of the sprite.
- `BIRD_W`, 4: sprite width in pixels.
- `BIRD_H`, 4: sprite height in pixels.
- `BIRD_COLOUR`, 3'b110: sprite colour (RGB, 1 bit each).
- `SKY_COLOUR`, 3'b011: erase colour.
- `clk` in 1: system clock. One clock domain; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: single-cycle pulse that starts one redraw.
- `bird_y` in 7: top row of the bird, as produced by the control FSM.
- `vga_x` out 8: pixel column.
- `vga_y` out 7: pixel row.
- `vga_colour` out 3: pixel colour.
- `vga_plot` out 1: write enable to the VGA adapter, one pixel per high cycle.
- `busy` out 1: high while a redraw is in progress (any state except IDLE).
- `frame_done` out 1: single-cycle pulse at the end of each accepted redraw.

## Operation
- States:
  - IDLE: waits for `frame_tick`.
  - ERASE: plots `SKY_COLOUR` over the old sprite position.
  - DRAW: plots `BIRD_COLOUR` at the new position.
  - DONE: updates the stored position and pulses `frame_done`.
- Internal registers:
  - `old_y` (7b): position of the sprite currently on screen.
  - `new_y` (7b): position latched for this redraw.
  - `have_old` (1b): a sprite is currently on screen.
  - `dx`, `dy`: pixel scan counters, each sized to hold `BIRD_W-1` / `BIRD_H-1`.
- In IDLE with `frame_tick`=1, latch `new_y` = min(`bird_y`, 120-`BIRD_H`), i.e. 116 at default parameters.
- Transitions out of IDLE on `frame_tick`:
  - `have_old`=1 and `new_y`≠`old_y`: go to ERASE.
  - `have_old`=0: go to DRAW.
  - `have_old`=1 and `new_y`==`old_y`: go to DONE. Nothing is plotted.
- Pixel scan in ERASE and DRAW:
  - `dx` is the inner loop and runs 0..`BIRD_W`-1; `dy` is the outer loop and runs 0..`BIRD_H`-1.
  - Each cycle outputs `vga_x`=`BIRD_X`+`dx` and `vga_y`=(`old_y` in ERASE, `new_y` in DRAW)+`dy`, with `vga_plot`=1.
  - After the last pixel (`dx`=`BIRD_W`-1, `dy`=`BIRD_H`-1), clear both counters and go ERASE→DRAW or DRAW→DONE.
- DONE lasts one cycle:
  - `old_y`<=`new_y`, `have_old`<=1.
  - `frame_done`=1.
  - Next state IDLE.
- `frame_tick` arriving while `busy`=1 is dropped. It is not queued.
- `bird_y` is sampled only in the tick cycle; changes during a redraw have no effect.
- Arithmetic is unsigned with no wrap:
  - Clamping guarantees `vga_y` ≤ 119.
  - `BIRD_X`+`BIRD_W`-1 ≤ 159 is a parameter legality requirement, checked by an elaboration-time assertion.
- When `vga_plot`=0, `vga_x`, `vga_y` and `vga_colour` are all 0.

## Timing
- Reset values:
  - state IDLE.
  - `vga_x`, `vga_y`, `vga_colour` = 0; `vga_plot`, `busy`, `frame_done` = 0.
  - `old_y`=0, `new_y`=0, `have_old`=0, `dx`=0, `dy`=0.
- Outputs are decoded only from registered state and counters. No input reaches an output combinationally.
- Tick sampled at cycle T, with N = `BIRD_W`*`BIRD_H` (16 at default parameters):
  - Erase + draw: ERASE plots on T+1..T+N, DRAW on T+N+1..T+2N, `frame_done` at T+2N+1. IDLE at T+2N+2, when a new tick is accepted.
  - First frame (`have_old`=0): DRAW on T+1..T+N, `frame_done` at T+N+1.
  - Unchanged y: `frame_done` at T+1, with no plots.
- Reset asserted mid-redraw:
  - The next cycle is IDLE with `vga_plot`=0.
  - `have_old` is cleared, so the next frame draws without erasing.
  - Clearing any stale sprite is the job of the top-level screen clear.

## Structure
- Shared package `bird_pkg`:
  - screen constants `SCREEN_W`=160 and `SCREEN_H`=120;
  - colour constants SKY, BIRD, PIPE;
  - the renderer state enum (IDLE, ERASE, DRAW, DONE).
- One sub-module, `sprite_scanner`: the `dx`/`dy` counter pair. It takes `start` and `enable` inputs and produces `dx`, `dy` and a `last` flag. It is instantiated once and reused by both ERASE and DRAW.

## Test plan
- Reset, then tick with `bird_y`=50 → 16 plots of colour 3'b110 at x 20..23, y 50..53, row-major; `frame_done` 17 cycles after the tick.
- Next tick with `bird_y`=52 → 16 plots of colour 3'b011 at y 50..53, then 16 plots of colour 3'b110 at y 52..55; `frame_done` at T+33.
- Tick with `bird_y`=52 again → zero plots and `frame_done` at T+1.
- Tick with `bird_y`=127 → clamped to 116: last plot is at (23,119) and no `vga_y` ever exceeds 119.
- Second tick issued at T+5 during a redraw → ignored: exactly one `frame_done`, and the total plot count is unchanged.
- Reset pulsed at T+10 mid-erase → `vga_plot`=0 from T+11; the following tick with `bird_y`=30 draws only, 16 plots, with no erase.
